cpu0_memory_ctrl: RTL



---
 rtl/cpu0_memory_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cpu0_memory_ctrl.sv
// Byte-addressable big-endian memory for the CPU0 bus with per-direction wait states
// and a one-cycle ready/err completion pulse.
module cpu0_memory_ctrl #(
  parameter int DEPTH   = 256,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  w1,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic            en_q;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     dout_q, dout_d;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            rw_q;
  logic [1:0]      w1_q;
  logic [7:0]      mem [DEPTH];

  logic            accept, range_bad, do_acc;
  logic [32:0]     last_addr;
  logic [3:0]      wcyc;
  // A zero-wait access happens on the acceptance edge itself, so the access
  // path reads the live bus in IDLE and the captured copy afterwards.
  logic [AW-1:0]   a_cur;
  logic [31:0]     d_cur;
  logic            rw_cur;
  logic [1:0]      w1_cur, sh;
  logic [31:0]     rdata;
  logic [7:0]      wbyte [4];

  assign accept    = (state_q == IDLE) && en && !en_q;
  assign last_addr = {1'b0, abus} + {31'b0, w1};
  assign range_bad = last_addr > 33'(DEPTH - 1);
  assign wcyc      = rw ? 4'(RD_WAIT) : 4'(WR_WAIT);

  assign a_cur  = (state_q == IDLE) ? abus[AW-1:0] : addr_q;
  assign d_cur  = (state_q == IDLE) ? dbus_in : wdata_q;
  assign rw_cur = (state_q == IDLE) ? rw : rw_q;
  assign w1_cur = (state_q == IDLE) ? w1 : w1_q;

  always_comb begin
    rdata = '0;
    sh    = '0;
    for (int i = 0; i < 4; i++) begin
      sh       = w1_cur - 2'(i);
      wbyte[i] = 8'(d_cur >> {sh, 3'b000});
      if (2'(i) <= w1_cur) rdata = {rdata[23:0], mem[a_cur + AW'(i)]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    dout_d  = dout_q;
    do_acc  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (range_bad) begin
          state_d = DONE;
          err_d   = 1'b1;
          dout_d  = '0;
        end else if (wcyc == 4'd0) begin
          do_acc  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = wcyc - 4'd1;
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        do_acc  = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (do_acc && rw_cur) dout_d = rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
    if (accept) begin
      addr_q  <= abus[AW-1:0];
      wdata_q <= dbus_in;
      rw_q    <= rw;
      w1_q    <= w1;
    end
  end

  // Contents survive reset; a reset on the commit edge drops the write.
  always_ff @(posedge clock) begin
    if (!reset && do_acc && !rw_cur)
      for (int i = 0; i < 4; i++)
        if (2'(i) <= w1_cur) mem[a_cur + AW'(i)] <= wbyte[i];
  end

  assign ready    = (state_q == DONE);
  assign err      = err_q;
  assign busy     = (state_q == WAIT);
  assign dbus_out = dout_q;
endmodule
